alu_result_fifo: RTL and testbench
==================================

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, minimum 2.
REQ-002 SHALL have parameter WIDTH, default 32, result data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  ALU result present.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept an entry.
REQ-007 SHALL have port in_y  input  WIDTH  ALU result Y.
REQ-008 SHALL have port in_flags  input  4  {Cout, Negative, Zero, Overflow} from ALU.
REQ-009 SHALL have port out_valid  output  1  head entry present.
REQ-010 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-011 SHALL have port out_y  output  WIDTH  head entry Y.
REQ-012 SHALL have port out_flags  output  4  head entry flags, same bit order as in_flags.
REQ-013 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port clr_sticky  input  1  clear sticky flag register.
REQ-015 SHALL have port sticky_flags  output  4  OR-accumulated flags of accepted entries.

Function
REQ-016 SHALL push {in_y, in_flags} when in_valid && in_ready at a rising clk edge; SHALL pop head when out_valid && out_ready.
REQ-017 SHALL drive in_ready = (count < DEPTH), combinational from registered count only; no full-pop bypass.
REQ-018 SHALL drive out_valid = (count != 0).
REQ-019 SHALL present a pushed entry on out_y/out_flags with out_valid=1 one cycle after acceptance (latency 1; no same-cycle pass-through).
REQ-020 SHALL drive out_y = 0 and out_flags = 0 while count = 0.
REQ-021 SHALL keep out_y/out_flags stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on simultaneous push and pop (count between 1 and DEPTH-1), leave count unchanged and preserve order.
REQ-023 SHALL wrap read and write pointers modulo DEPTH; order strictly first-in first-out across wrap.
REQ-024 SHALL ignore in_valid while full (entry not stored, upstream must hold); SHALL ignore out_ready while empty.
REQ-025 SHALL update count: +1 push only, -1 pop only, unchanged otherwise; range 0..DEPTH.
REQ-026 SHALL ignore in_y/in_flags values when in_valid=0, including X.

Reset
REQ-027 SHALL, on rst_n low, immediately clear count, pointers and sticky_flags; out_valid=0, in_ready=1, out_y=0, out_flags=0, regardless of clk.
REQ-028 SHALL discard all stored entries on reset mid-operation; first push after rst_n rises is the next head.
REQ-029 SHALL not require storage array reset; unread storage never appears on outputs.

Configuration
REQ-030 SHALL implement sticky flags only when macro ALU_RESULT_FIFO_STICKY_EN is defined.
REQ-031 With ALU_RESULT_FIFO_STICKY_EN: sticky_flags |= in_flags on every accepted push; clr_sticky=1 clears to 0; clr_sticky and push same cycle yields sticky_flags = pushed in_flags (clear first, then set); rejected pushes do not affect sticky_flags.
REQ-032 Without ALU_RESULT_FIFO_STICKY_EN: sticky_flags tied to 4'b0000, clr_sticky ignored, ports retained.

Verification
REQ-033 Single push in_y=32'h0000_00A5, in_flags=4'b0010 -> next cycle out_valid=1, out_y=32'h0000_00A5, out_flags=4'b0010, count=1.
REQ-034 Push 4 entries 1,2,3,4 with out_ready=0 -> count=4, in_ready=0; 5th push value 5 rejected; then out_ready=1 drains 1,2,3,4 in order, count returns 0, out_y=0.
REQ-035 Continuous push+pop for 10 cycles, values 10..19, DEPTH=4 -> outputs 10..19 in order across pointer wrap, count steady at 1.
REQ-036 count=3, assert rst_n=0 between clk edges -> count=0, out_valid=0, in_ready=1 immediately; after release push 32'hDEAD_BEEF appears as head.
REQ-037 Macro defined: push flags 4'b1000 then 4'b0001 -> sticky_flags=4'b1001; clr_sticky with push 4'b0100 -> sticky_flags=4'b0100.
REQ-038 Macro undefined: same stimulus as REQ-037 -> sticky_flags=4'b0000 throughout.

Source files
------------

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: small FIFO that buffers ALU results {Y, flags} between an
// ALU and its consumer using valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready/in_y/in_flags  push side; flags = {Cout, N, Z, V}
//   out_valid/out_ready/out_y/out_flags  pop side; outputs are 0 when empty
//   count                          occupancy, 0..DEPTH
//   clr_sticky/sticky_flags        OR-accumulated flags of accepted pushes
// Optional: define ALU_RESULT_FIFO_STICKY_EN to enable sticky flags;
// otherwise sticky_flags is tied to 0 and clr_sticky is ignored.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_y,
    input  logic [3:0]               in_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     clr_sticky,
    output logic [3:0]               sticky_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] y_mem_q [DEPTH];
    logic [3:0]       f_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Storage is never read while empty, so it needs no reset.
    assign out_y     = out_valid ? y_mem_q[rd_ptr_q] : '0;
    assign out_flags = out_valid ? f_mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            y_mem_q[wr_ptr_q] <= in_y;
            f_mem_q[wr_ptr_q] <= in_flags;
        end
    end

`ifdef ALU_RESULT_FIFO_STICKY_EN
    logic [3:0] sticky_q, sticky_d;

    // Clear takes effect before the same-cycle push is OR-ed in.
    always_comb begin
        sticky_d = sticky_q;
        if (clr_sticky) sticky_d = '0;
        if (push)       sticky_d = sticky_d | in_flags;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= '0;
        else        sticky_q <= sticky_d;
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky_flags      = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed self-checking bench for alu_result_fifo
// (DEPTH=4, WIDTH=32), covering reset, ordering, full/empty and sticky flags.
module tb_alu_result_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_y;
    logic [3:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_flags;
    logic [2:0]  count;
    logic        clr_sticky;
    logic [3:0]  sticky_flags;

    int total = 0;
    int bad   = 0;

`ifdef ALU_RESULT_FIFO_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    alu_result_fifo #(.DEPTH(4), .WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_y         (in_y),
        .in_flags     (in_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_flags    (out_flags),
        .count        (count),
        .clr_sticky   (clr_sticky),
        .sticky_flags (sticky_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] se(input logic [3:0] v);
        return STK ? v : 4'b0000;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_y       = '0;
        in_flags   = '0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_iready", in_ready, 1);
        chk("rst_oy", out_y, 0);
        chk("rst_oflags", out_flags, 0);
        chk("rst_sticky", sticky_flags, 0);
        rst_n = 1'b1;
        tick();

        // single push
        in_valid = 1'b1;
        in_y     = 32'h0000_00A5;
        in_flags = 4'b0010;
        tick();
        in_valid = 1'b0;
        in_y     = 'x;
        in_flags = 'x;
        chk("one_ovalid", out_valid, 1);
        chk("one_oy", out_y, 32'h0000_00A5);
        chk("one_oflags", out_flags, 4'b0010);
        chk("one_count", count, 1);
        chk("one_sticky", sticky_flags, se(4'b0010));
        tick();
        chk("one_hold_oy", out_y, 32'h0000_00A5);
        chk("one_hold_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("one_pop_count", count, 0);
        chk("one_pop_oy", out_y, 0);
        chk("one_pop_ovalid", out_valid, 0);

        // fill to full, reject fifth, then drain
        in_flags = 4'b0000;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_y     = i;
            tick();
        end
        in_valid = 1'b0;
        chk("full_count", count, 4);
        chk("full_iready", in_ready, 0);
        in_valid = 1'b1;
        in_y     = 5;
        in_flags = 4'b1111;
        tick();
        in_valid = 1'b0;
        in_flags = 4'b0000;
        chk("rej_count", count, 4);
        chk("rej_head", out_y, 1);
        chk("rej_sticky", sticky_flags, se(4'b0010));
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_oy", out_y, i);
            tick();
        end
        chk("drain_count", count, 0);
        chk("drain_oy0", out_y, 0);
        tick();
        chk("empty_pop_count", count, 0);
        chk("empty_iready", in_ready, 1);

        // streaming push+pop across pointer wrap
        in_valid = 1'b1;
        in_y     = 10;
        tick();
        for (int i = 11; i <= 19; i++) begin
            in_y = i;
            chk("stream_oy", out_y, i - 1);
            tick();
            chk("stream_count", count, 1);
        end
        in_valid = 1'b0;
        chk("stream_last", out_y, 19);
        tick();
        out_ready = 1'b0;
        chk("stream_end_count", count, 0);

        // async reset mid-operation
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_y = 32'h100 + i;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_count", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_ovalid", out_valid, 0);
        chk("arst_iready", in_ready, 1);
        chk("arst_oy", out_y, 0);
        chk("arst_sticky", sticky_flags, 0);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_y     = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        chk("post_rst_head", out_y, 32'hDEAD_BEEF);
        chk("post_rst_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_rst_empty", count, 0);

        // sticky flags
        in_valid = 1'b1;
        in_flags = 4'b1000;
        in_y     = 32'h1;
        tick();
        in_flags = 4'b0001;
        in_y     = 32'h2;
        tick();
        chk("stk_or", sticky_flags, se(4'b1001));
        clr_sticky = 1'b1;
        in_flags   = 4'b0100;
        in_y       = 32'h3;
        tick();
        clr_sticky = 1'b0;
        in_valid   = 1'b0;
        chk("stk_clr_push", sticky_flags, se(4'b0100));
        out_ready = 1'b1;
        chk("stk_f0", out_flags, 4'b1000);
        tick();
        chk("stk_f1", out_flags, 4'b0001);
        tick();
        chk("stk_f2", out_flags, 4'b0100);
        chk("stk_y2", out_y, 32'h3);
        tick();
        out_ready = 1'b0;
        chk("stk_end_count", count, 0);
        chk("stk_end_sticky", sticky_flags, se(4'b0100));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
